// File: rtl/dec_onehot_pkg.sv
// Shared types for the sequenced one-hot decoder: mode encoding and FSM states.
package dec_onehot_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_PULSE  = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_SCAN  = 2'b10
  } state_t;

endpackage

// File: rtl/dec_onehot.sv
// Combinational binary-to-one-hot decoder with enable; all-zero when disabled.
module dec_onehot #(
  parameter int AW = 4
) (
  input  logic [AW-1:0]      i_code,
  input  logic               i_en,
  output logic [(1<<AW)-1:0] o_z
);

  localparam int NO = 1 << AW;

  always_comb begin
    o_z = '0;
    if (i_en) o_z[i_code] = 1'b1;
  end

endmodule

// File: rtl/dec_onehot_seq.sv
// Registered one-hot decoder with DIRECT, timed PULSE and stepped SCAN modes.
// Build option: define DEC_ACTIVE_LOW_EN for one-cold (active-low) z outputs.
module dec_onehot_seq
  import dec_onehot_pkg::*;
#(
  parameter int AW = 4,
  parameter int PW = 4
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                gn,
  input  logic [1:0]          mode,
  input  logic [AW-1:0]       a,
  input  logic                load,
  input  logic [PW-1:0]       plen,
  input  logic                step,
  output logic [(1<<AW)-1:0]  z,
  output logic                busy,
  output logic                done,
  output state_t              o_dbg_state
);

  localparam int NO = 1 << AW;

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [NO-1:0] Z_INV = '1;
`else
  localparam logic [NO-1:0] Z_INV = '0;
`endif

  state_t          r_state, w_nxt_state;
  logic [AW-1:0]   r_idx, w_nxt_idx;
  logic [PW-1:0]   r_cnt, w_nxt_cnt;
  logic [NO-1:0]   r_z;
  logic            r_busy, r_done;
  logic            w_nxt_busy, w_nxt_done;
  logic            w_dec_en;
  logic [AW-1:0]   w_dec_code;
  logic [NO-1:0]   w_dec_z;
  mode_t           w_mode;

  assign w_mode = mode_t'(mode);

  dec_onehot #(.AW(AW)) u_dec (
    .i_code (w_dec_code),
    .i_en   (w_dec_en),
    .o_z    (w_dec_z)
  );

  // The decoder output computed here is what z shows after the next edge.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_cnt   = r_cnt;
    w_nxt_busy  = 1'b0;
    w_nxt_done  = 1'b0;
    w_dec_en    = 1'b0;
    w_dec_code  = r_idx;
    unique case (r_state)
      ST_IDLE: begin
        w_nxt_cnt = '0;
        if (!gn) begin
          unique case (w_mode)
            MODE_DIRECT: begin
              w_dec_en   = 1'b1;
              w_dec_code = a;
            end
            MODE_PULSE: if (load) begin
              w_nxt_state = ST_PULSE;
              w_nxt_idx   = a;
              w_nxt_cnt   = plen;
              w_nxt_busy  = 1'b1;
              w_dec_en    = 1'b1;
              w_dec_code  = a;
            end
            MODE_SCAN: if (load) begin
              w_nxt_state = ST_SCAN;
              w_nxt_idx   = a;
              w_nxt_busy  = 1'b1;
              w_dec_en    = 1'b1;
              w_dec_code  = a;
            end
            default: ;
          endcase
        end
      end
      ST_PULSE: begin
        if (gn || w_mode != MODE_PULSE) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
        end else if (r_cnt == '0) begin
          w_nxt_state = ST_IDLE;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_cnt  = r_cnt - PW'(1);
          w_nxt_busy = 1'b1;
          w_dec_en   = 1'b1;
        end
      end
      ST_SCAN: begin
        if (gn || w_mode != MODE_SCAN) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_busy = 1'b1;
          w_dec_en   = 1'b1;
          if (load) begin
            w_nxt_idx  = a;
            w_dec_code = a;
          end else if (step) begin
            w_nxt_idx  = r_idx + AW'(1);
            w_dec_code = r_idx + AW'(1);
            w_nxt_done = (r_idx == AW'(NO - 1));
          end
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_z     <= Z_INV;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_cnt   <= w_nxt_cnt;
      r_z     <= w_dec_z ^ Z_INV;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
    end
  end

  assign z           = r_z;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule
